// File: rtl/alsu_pkg.sv
// Shared ALSU command/response layout, opcode constants and LED error encoding
// for the ALSU command master slice.
package alsu_pkg;

  localparam int unsigned CMD_W     = 16;
  localparam int unsigned RSP_W     = 10;
  localparam int unsigned F_A_LSB   = 0;
  localparam int unsigned F_B_LSB   = 3;
  localparam int unsigned F_OP_LSB  = 6;
  localparam int unsigned F_OPND_W  = 3;
  localparam int unsigned F_OP_W    = 3;
  localparam int unsigned F_CIN     = 9;
  localparam int unsigned F_SER     = 10;
  localparam int unsigned F_DIR     = 11;
  localparam int unsigned F_RED_A   = 12;
  localparam int unsigned F_RED_B   = 13;
  localparam int unsigned F_BYP_A   = 14;
  localparam int unsigned F_BYP_B   = 15;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_XOR   = 3'b001,
    OP_ADD   = 3'b010,
    OP_MUL   = 3'b011,
    OP_SHIFT = 3'b100,
    OP_ROT   = 3'b101
  } alsu_op_e;

  localparam logic [15:0] LEDS_ERR = 16'hFFFF;
  localparam logic [15:0] IDLE_CMD = 16'h0000;

  // Opcode is kept as raw bits: 110/111 are legal to send (ALSU flags them).
  typedef struct packed {
    logic       bypass_b;
    logic       bypass_a;
    logic       red_op_b;
    logic       red_op_a;
    logic       direction;
    logic       serial_in;
    logic       cin;
    logic [2:0] opcode;
    logic [2:0] b;
    logic [2:0] a;
  } alsu_cmd_t;

  typedef struct packed {
    logic [5:0] data;
    logic       err;
    logic [2:0] opcode;
  } alsu_rsp_t;

  function automatic logic leds_is_err(input logic [15:0] leds);
    return leds == LEDS_ERR;
  endfunction

endpackage

// File: rtl/alsu_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO for ALSU responses; extra pointer
// bit separates full from empty.
module alsu_rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_count   = r_wr - r_rd;
  assign o_data    = r_mem[r_rd[AW-1:0]];
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr[AW-1:0]] <= i_data;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/alsu_cmd_master.sv
// ALSU command master: issues packed commands to an ALSU, tracks its latency and
// buffers responses in order. ALSU_MASTER_STATS_EN adds command/error counters.
module alsu_cmd_master
  import alsu_pkg::*;
#(
  parameter int unsigned ALSU_LATENCY = 2,
  parameter int unsigned RSP_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic [2:0]  alsu_A,
  output logic [2:0]  alsu_B,
  output logic [2:0]  alsu_opcode,
  output logic        alsu_cin,
  output logic        alsu_serial_in,
  output logic        alsu_direction,
  output logic        alsu_red_op_A,
  output logic        alsu_red_op_B,
  output logic        alsu_bypass_A,
  output logic        alsu_bypass_B,
  input  logic [5:0]  alsu_out,
  input  logic [15:0] alsu_leds,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_data,
  output logic        rsp_err,
  output logic [2:0]  rsp_opcode
`ifdef ALSU_MASTER_STATS_EN
  ,
  output logic [15:0] stat_cmd_cnt,
  output logic [15:0] stat_err_cnt
`endif
);

  localparam int unsigned IW = $clog2(ALSU_LATENCY + 2);
  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;

  alsu_cmd_t             w_cmd;
  alsu_cmd_t             r_drive;
  logic                  w_accept;
  logic [ALSU_LATENCY:0] r_pipe_vld;
  logic [2:0]            r_pipe_op [ALSU_LATENCY+1];
  logic [IW-1:0]         r_inflight;
  logic                  w_push;
  alsu_rsp_t             w_push_data;
  alsu_rsp_t             w_head;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [31:0]           w_occ;

  assign w_cmd    = alsu_cmd_t'(cmd_data);
  assign w_accept = cmd_valid && cmd_ready;

  // Occupancy counts both buffered and in-flight results, so a slot is
  // reserved at issue time and the FIFO cannot overflow.
  assign w_occ     = 32'(w_count) + 32'(r_inflight);
  assign cmd_ready = (w_occ < RSP_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_drive <= alsu_cmd_t'(IDLE_CMD);
    else     r_drive <= w_accept ? w_cmd : alsu_cmd_t'(IDLE_CMD);
  end

  assign alsu_A         = r_drive.a;
  assign alsu_B         = r_drive.b;
  assign alsu_opcode    = r_drive.opcode;
  assign alsu_cin       = r_drive.cin;
  assign alsu_serial_in = r_drive.serial_in;
  assign alsu_direction = r_drive.direction;
  assign alsu_red_op_A  = r_drive.red_op_a;
  assign alsu_red_op_B  = r_drive.red_op_b;
  assign alsu_bypass_A  = r_drive.bypass_a;
  assign alsu_bypass_B  = r_drive.bypass_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int unsigned i = 0; i <= ALSU_LATENCY; i++) r_pipe_op[i] <= '0;
    end else begin
      r_pipe_vld   <= {r_pipe_vld[ALSU_LATENCY-1:0], w_accept};
      r_pipe_op[0] <= w_accept ? w_cmd.opcode : '0;
      for (int unsigned i = 1; i <= ALSU_LATENCY; i++) r_pipe_op[i] <= r_pipe_op[i-1];
    end
  end

  assign w_push             = r_pipe_vld[ALSU_LATENCY];
  assign w_push_data.data   = alsu_out;
  assign w_push_data.err    = leds_is_err(alsu_leds);
  assign w_push_data.opcode = r_pipe_op[ALSU_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  alsu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (rsp_valid && rsp_ready),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign rsp_valid  = !w_empty;
  assign rsp_data   = w_head.data;
  assign rsp_err    = w_head.err;
  assign rsp_opcode = w_head.opcode;

`ifdef ALSU_MASTER_STATS_EN
  logic [15:0] r_stat_cmd;
  logic [15:0] r_stat_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_cmd <= '0;
      r_stat_err <= '0;
    end else begin
      if (w_accept && (r_stat_cmd != '1)) r_stat_cmd <= r_stat_cmd + 16'd1;
      if (w_push && w_push_data.err && (r_stat_err != '1)) r_stat_err <= r_stat_err + 16'd1;
    end
  end

  assign stat_cmd_cnt = r_stat_cmd;
  assign stat_err_cnt = r_stat_err;
`endif

endmodule

// File: tb/tb_alsu_cmd_master.sv
// Self-checking bench for alsu_cmd_master with a stand-in two-stage ALSU model
// and a queue-based reference of accepted-but-unconsumed commands.
module tb_alsu_cmd_master;
  import alsu_pkg::*;

  localparam int RSP_DEPTH = 4;
  localparam int LAT_EXP   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = '0;
  logic [2:0]  alsu_A, alsu_B, alsu_opcode;
  logic        alsu_cin, alsu_serial_in, alsu_direction;
  logic        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [5:0]  rsp_data;
  logic        rsp_err;
  logic [2:0]  rsp_opcode;
`ifdef ALSU_MASTER_STATS_EN
  logic [15:0] stat_cmd_cnt, stat_err_cnt;
`endif

  alsu_cmd_master #(.ALSU_LATENCY(2), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
    .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
    .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_opcode(rsp_opcode)
`ifdef ALSU_MASTER_STATS_EN
    , .stat_cmd_cnt(stat_cmd_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in ALSU (full adder on, A priority): result as {err, out[5:0]}.
  function automatic logic [6:0] alsu_eval(input logic [15:0] c);
    logic [2:0] a, b, op;
    logic [5:0] ab, o;
    logic inv;
    a = c[2:0]; b = c[5:3]; op = c[8:6]; ab = {a, b};
    inv = (op > 3'd5) || ((c[12] || c[13]) && (op > 3'd1));
    if (c[14])      o = {3'b0, a};
    else if (c[15]) o = {3'b0, b};
    else if (inv)   o = 6'd0;
    else begin
      case (op)
        3'd0:    o = c[12] ? {5'b0, &a} : c[13] ? {5'b0, &b} : {3'b0, a & b};
        3'd1:    o = c[12] ? {5'b0, ^a} : c[13] ? {5'b0, ^b} : {3'b0, a ^ b};
        3'd2:    o = 6'(a + b + c[9]);
        3'd3:    o = 6'(a * b);
        3'd4:    o = c[11] ? {ab[4:0], c[10]} : {c[10], ab[5:1]};
        default: o = c[11] ? {ab[4:0], ab[5]} : {ab[0], ab[5:1]};
      endcase
    end
    return {inv, o};
  endfunction

  logic [15:0] m_in;
  logic [5:0]  m_out;
  logic        m_err;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in <= '0; m_out <= '0; m_err <= 1'b0;
    end else begin
      m_in <= {alsu_bypass_B, alsu_bypass_A, alsu_red_op_B, alsu_red_op_A, alsu_direction,
               alsu_serial_in, alsu_cin, alsu_opcode, alsu_B, alsu_A};
      {m_err, m_out} <= alsu_eval(m_in);
    end
  end
  assign alsu_out  = m_out;
  assign alsu_leds = m_err ? 16'hFFFF : 16'h0000;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [9:0] word; int acc_cyc; } exp_t;
  exp_t       exp_q[$];
  logic [9:0] got_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] ref_rsp(input logic [15:0] c);
    logic [6:0] r;
    r = alsu_eval(c);
    return {r[5:0], r[6], c[8:6]};
  endfunction

  // One cycle: drive at negedge, check against reference, advance to next negedge.
  task automatic step(input logic v, input logic [15:0] d, input logic rr, output logic acc);
    logic exp_v;
    logic [9:0] pv;
    cmd_valid = v; cmd_data = d; rsp_ready = rr;
    check("cmd_ready", 32'(cmd_ready), 32'(exp_q.size() < RSP_DEPTH));
    exp_v = (exp_q.size() > 0) && (exp_q[0].acc_cyc + LAT_EXP <= cyc);
    check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    pv = {rsp_data, rsp_err, rsp_opcode};
    if (rsp_valid && rr) begin
      if (exp_q.size() == 0) check("rsp_extra", 32'(1), 32'(0));
      else begin
        check("rsp_word", 32'(pv), 32'(exp_q[0].word));
        void'(exp_q.pop_front());
      end
      got_q.push_back(pv);
    end
    acc = v && cmd_ready;
    if (acc) exp_q.push_back('{word: ref_rsp(d), acc_cyc: cyc + 1});
    @(negedge clk);
  endtask

  task automatic drain();
    logic a;
    got_q.delete();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step(1'b0, 16'h0, 1'b1, a);
    check("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_drive"}, 32'({alsu_bypass_B, alsu_bypass_A, alsu_red_op_B, alsu_red_op_A,
          alsu_direction, alsu_serial_in, alsu_cin, alsu_opcode, alsu_B, alsu_A}), 32'(0));
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, "_rsp"}, 32'({rsp_data, rsp_err, rsp_opcode}), 32'(0));
  endtask

  initial begin
    logic a;
    int   lat, acc_edge, n_acc;
    logic [15:0] d;
    logic hold_v;

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back MUL then invalid opcode.
    step(1'b1, 16'h00FF, 1'b1, a); check("b2b_acc0", 32'(a), 32'(1));
    step(1'b1, 16'h0180, 1'b1, a); check("b2b_acc1", 32'(a), 32'(1));
    drain();
    check("b2b_n", 32'(got_q.size()), 32'(2));
    if (got_q.size() == 2) begin
      check("mul_rsp", 32'(got_q[0]), 32'({6'h31, 1'b0, 3'b011}));
      check("inv_rsp", 32'(got_q[1]), 32'({6'h00, 1'b1, 3'b110}));
    end
`ifdef ALSU_MASTER_STATS_EN
    check("stat_cmd", 32'(stat_cmd_cnt), 32'(2));
    check("stat_err", 32'(stat_err_cnt), 32'(1));
`endif

    // Single ADD and its latency.
    step(1'b1, 16'h02AB, 1'b0, a); check("add_acc", 32'(a), 32'(1));
    acc_edge = cyc; lat = 99;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) begin lat = cyc - acc_edge; break; end
      step(1'b0, 16'h0, 1'b0, a);
    end
    check("add_lat", 32'(lat), 32'(3));
    drain();
    if (got_q.size() == 1) check("add_rsp", 32'(got_q[0]), 32'({6'd9, 1'b0, 3'b010}));
    else check("add_n", 32'(got_q.size()), 32'(1));

    // Bypass wins over invalid opcode.
    step(1'b1, 16'h41C5, 1'b1, a);
    drain();
    if (got_q.size() == 1) check("byp_rsp", 32'(got_q[0]), 32'({6'd5, 1'b1, 3'b111}));
    else check("byp_n", 32'(got_q.size()), 32'(1));

    // Credits exhausted with consumer stalled.
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      d = 16'h0008 * 16'(n_acc + 1) | 16'h0080;
      if (n_acc < 6) begin step(1'b1, d, 1'b0, a); if (a) n_acc++; end
      else step(1'b0, 16'h0, 1'b0, a);
    end
    check("full_acc", 32'(n_acc), 32'(4));
    check("full_ready", 32'(cmd_ready), 32'(0));
    drain();
    check("full_n", 32'(got_q.size()), 32'(4));

    // Reset with two in flight and one buffered.
    for (int i = 0; i < 3; i++) step(1'b1, 16'h00FF, 1'b0, a);
    step(1'b0, 16'h0, 1'b0, a);
    check("pre_rst_valid", 32'(rsp_valid), 32'(1));
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1, a);
    step(1'b1, 16'h02AB, 1'b1, a);
    drain();
    if (got_q.size() == 1) check("post_rst_rsp", 32'(got_q[0]), 32'({6'd9, 1'b0, 3'b010}));
    else check("post_rst_n", 32'(got_q.size()), 32'(1));

    // Random traffic; a stalled offer is held until accepted.
    hold_v = 1'b0; d = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!hold_v) begin
        hold_v = ($urandom_range(0, 9) < 7);
        d = 16'($urandom());
      end
      step(hold_v, d, $urandom_range(0, 9) < 6, a);
      if (a) hold_v = 1'b0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alsu_cmd_master.md
Name: alsu_cmd_master

Overview:
- Initiator side of the ALSU port interface.
- Accepts packed 16-bit ALSU commands over a valid/ready stream and drives them into the ALSU input pins, one per cycle, back-to-back.
- Tracks the fixed ALSU pipeline latency, then captures out/leds into an in-order response buffer with its own valid/ready handshake.
- Sits between a test sequencer or host bus bridge and an ALSU instance.

Parameters:
- ALSU_LATENCY, 2: edges from the master's drive-register update until the ALSU out/leds hold that command's result.
- RSP_DEPTH, 4: response FIFO depth. Power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clk edge
- cmd_data  in  16  packed command: [2:0] A, [5:3] B, [8:6] opcode, [9] cin, [10] serial_in, [11] direction, [12] red_op_A, [13] red_op_B, [14] bypass_A, [15] bypass_B
- alsu_A, alsu_B, alsu_opcode  out  3 each  registered drive to ALSU
- alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B  out  1 each  registered drive to ALSU
- alsu_out  in  6  ALSU result
- alsu_leds  in  16  ALSU warning LEDs
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a clk edge
- rsp_data  out  6  captured alsu_out
- rsp_err  out  1  captured (alsu_leds == 16'hFFFF)
- rsp_opcode  out  3  opcode of the originating command

Behaviour:
- Reset:
  - All alsu_* drive outputs are 0. This is the idle word: opcode 000 AND, no reduction, no bypass, never an error.
  - In-flight pipeline cleared; FIFO emptied; rsp_valid=0; rsp_data/rsp_err/rsp_opcode=0.
  - cmd_ready=1 after reset deasserts.
- Issue:
  - On an accept edge E0, the drive registers load the cmd_data fields.
  - On any edge with no accept, the drive registers load the idle word, so each command is presented for exactly one cycle.
- Tracking:
  - A valid/opcode shift pipeline of length ALSU_LATENCY+1 advances every cycle.
  - At edge E0+ALSU_LATENCY+1, the master samples alsu_out/alsu_leds (stable since E0+ALSU_LATENCY) and pushes {data, err, opcode} into the FIFO.
  - Idle slots never push.
- Latency:
  - rsp_valid rises no earlier than 3 cycles after the accept edge (default parameters).
  - Throughput is 1 command per cycle when rsp_ready is held high.
- Flow control (credits):
  - credits = RSP_DEPTH - fifo_count - inflight_count.
  - cmd_ready = (credits != 0), computed from registered state only. No combinational path from cmd_valid or rsp_ready.
  - The FIFO can never overflow, even with rsp_ready stuck low.
- Simultaneous events:
  - Accept, FIFO push and FIFO pop in the same edge all apply. A pop in edge N frees a credit visible in cycle N+1.
- FIFO:
  - First-word fall-through: rsp_* present the head whenever rsp_valid=1, held stable while rsp_ready=0.
  - Pointers wrap modulo RSP_DEPTH.
  - Full and empty are distinguished with an extra pointer bit.
- Ordering: responses come out strictly in command order.
- Reset mid-operation: in-flight commands and buffered responses are discarded; no response is emitted for them.

Optional Feature:
- Macro ALSU_MASTER_STATS_EN.
- When defined:
  - Adds outputs stat_cmd_cnt[15:0] (accepted commands) and stat_err_cnt[15:0] (pushed responses with err=1).
  - Both saturate at 16'hFFFF and are cleared by rst.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package alsu_pkg:
  - Command field offsets/widths.
  - Opcode constants: OP_AND=000, OP_XOR=001, OP_ADD=010, OP_MUL=011, OP_SHIFT=100, OP_ROT=101.
  - LEDS_ERR=16'hFFFF.
  - IDLE_CMD=16'h0000.
- Sub-module alsu_rsp_fifo: 10-bit-wide synchronous FWFT FIFO, parameter DEPTH, exposes count.

Test Plan (ALSU FULL_ADDER="ON", INPUT_PRIORITY="A", shared clk/rst):
- cmd_data=16'h02AB (A=3, B=5, ADD, cin=1) -> one response: rsp_data=9, rsp_err=0, rsp_opcode=010; rsp_valid first high 3 cycles after accept.
- Back-to-back 16'h00FF (7*7 MUL) then 16'h0180 (opcode 110), rsp_ready=1 -> responses in order: (6'h31, err=0), then (0, err=1).
- 16'h41C5 (opcode 111, A=5, bypass_A) -> rsp_data=5, rsp_err=1.
- rsp_ready=0, offer 6 commands continuously -> exactly 4 accepted, cmd_ready=0 thereafter. Raise rsp_ready -> 4 responses in order, cmd_ready returns 1 the cycle after the first pop.
- Assert rst with 2 in flight and 1 buffered -> all drive outputs 0, rsp_valid=0, no stale response after release; next command completes normally.
- With ALSU_MASTER_STATS_EN, run the second scenario -> stat_cmd_cnt=2, stat_err_cnt=1.
